// File: rtl/writeback_unit.sv
// Writeback stage: owns the register file write port, merging ALU results with
// formatted load returns held in a small in-order queue that ALU writes can squash.
module writeback_unit #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     aluValid,
  input  logic [4:0]               aluRd,
  input  logic [31:0]              aluResult,
  input  logic                     loadValid,
  output logic                     loadReady,
  input  logic [4:0]               loadRd,
  input  logic [31:0]              loadData,
  input  logic [2:0]               loadFunct3,
  input  logic [1:0]               loadOffset,
  output logic                     writeEn,
  output logic [4:0]               writeAddr,
  output logic [31:0]              writeData,
  output logic [31:0]              pendingMask,
  output logic [$clog2(DEPTH):0]   pendingCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    head_reg;
  logic [AW-1:0]    tail_reg;
  logic [CW-1:0]    count_reg;
  logic [DEPTH-1:0] live_reg;
  logic [4:0]       rd_reg   [DEPTH];
  logic [31:0]      data_reg [DEPTH];
  logic [31:0]      mask_term [DEPTH];

  logic        write_en_reg;
  logic [4:0]  write_addr_reg;
  logic [31:0] write_data_reg;

  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_fmt;
  logic        alu_wr;
  logic        load_accept;
  logic        enq;
  logic        pop;
  logic [31:0] mask_all;

  always_comb begin
    load_byte = loadData[{loadOffset, 3'b000} +: 8];
    load_half = loadOffset[1] ? loadData[31:16] : loadData[15:0];
    case (loadFunct3)
      3'b000:  load_fmt = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_fmt = {{16{load_half[15]}}, load_half};
      3'b100:  load_fmt = {24'd0, load_byte};
      3'b101:  load_fmt = {16'd0, load_half};
      default: load_fmt = loadData;
    endcase
  end

  assign loadReady   = !rst && (count_reg < CW'(DEPTH));
  assign alu_wr      = aluValid && (aluRd != 5'd0);
  assign load_accept = loadValid && loadReady;
  // A same-edge ALU write to the same rd makes the returning load dead on arrival.
  assign enq = load_accept && (loadRd != 5'd0) && !(alu_wr && (aluRd == loadRd));
  assign pop = !alu_wr && (count_reg != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      write_en_reg   <= 1'b0;
      write_addr_reg <= 5'd0;
      write_data_reg <= 32'd0;
    end else begin
      if (enq) tail_reg <= tail_reg + 1'b1;
      if (pop) head_reg <= head_reg + 1'b1;
      count_reg <= count_reg + CW'(enq) - CW'(pop);
      if (alu_wr) begin
        write_en_reg   <= 1'b1;
        write_addr_reg <= aluRd;
        write_data_reg <= aluResult;
      end else if (pop) begin
        // A squashed head still consumes its slot, just without a write.
        write_en_reg   <= live_reg[head_reg];
        write_addr_reg <= rd_reg[head_reg];
        write_data_reg <= data_reg[head_reg];
      end else begin
        write_en_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        live_reg[i] <= 1'b0;
      end else if (enq && (tail_reg == AW'(i))) begin
        live_reg[i] <= 1'b1;
        rd_reg[i]   <= loadRd;
        data_reg[i] <= load_fmt;
      end else if ((pop && (head_reg == AW'(i))) || (alu_wr && (rd_reg[i] == aluRd))) begin
        live_reg[i] <= 1'b0;
      end
    end
  end

  // Entries are cleared on pop, so live alone marks in-flight destinations.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_mask
      assign mask_term[gi] = live_reg[gi] ? (32'd1 << rd_reg[gi]) : 32'd0;
    end
  endgenerate

  always_comb begin
    mask_all = 32'd0;
    for (int i = 0; i < DEPTH; i++) mask_all = mask_all | mask_term[i];
  end

  assign pendingMask  = {mask_all[31:1], 1'b0};
  assign pendingCount = count_reg;
  assign writeEn      = write_en_reg;
  assign writeAddr    = write_addr_reg;
  assign writeData    = write_data_reg;

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: stimulus pushes expected writes, a
// negedge monitor pops and compares every asserted write.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        aluValid;
  logic [4:0]  aluRd;
  logic [31:0] aluResult;
  logic        loadValid;
  logic        loadReady;
  logic [4:0]  loadRd;
  logic [31:0] loadData;
  logic [2:0]  loadFunct3;
  logic [1:0]  loadOffset;
  logic        writeEn;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;
  logic [31:0] pendingMask;
  logic [2:0]  pendingCount;

  int errors = 0;
  int checks = 0;
  logic [36:0] exp_q[$];

  writeback_unit #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .aluValid(aluValid), .aluRd(aluRd), .aluResult(aluResult),
    .loadValid(loadValid), .loadReady(loadReady), .loadRd(loadRd),
    .loadData(loadData), .loadFunct3(loadFunct3), .loadOffset(loadOffset),
    .writeEn(writeEn), .writeAddr(writeAddr), .writeData(writeData),
    .pendingMask(pendingMask), .pendingCount(pendingCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Monitor: every asserted write must match the oldest expectation.
  always @(negedge clk) begin
    if (writeEn === 1'b1) begin
      logic [36:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got x%0d=0x%08h expected no write", writeAddr, writeData);
      end else begin
        e = exp_q.pop_front();
        if ({writeAddr, writeData} !== e) begin
          errors++;
          $display("FAIL write_seq: got x%0d=0x%08h expected x%0d=0x%08h",
                   writeAddr, writeData, e[36:32], e[31:0]);
        end else begin
          $display("ok   write x%0d=0x%08h", writeAddr, writeData);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    aluValid = 1'b0; aluRd = 5'd0; aluResult = 32'd0;
    loadValid = 1'b0; loadRd = 5'd0; loadData = 32'd0;
    loadFunct3 = 3'd2; loadOffset = 2'd0;
  endtask

  // Single load into an idle queue: checks acceptance, N+1 bubble, then the write.
  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3,
                         input logic [1:0] off, input logic [31:0] exp);
    loadValid = 1'b1; loadRd = rd; loadData = 32'h80F17F01;
    loadFunct3 = f3; loadOffset = off;
    exp_q.push_back({rd, exp});
    @(negedge clk);
    check("fmt_ready", 32'(loadReady), 32'd1);
    next_cycle();
    loadValid = 1'b0;
    @(negedge clk);
    check("fmt_bubble_we", 32'(writeEn), 32'd0);
    check("fmt_mask", pendingMask, 32'd1 << rd);
    next_cycle();
    @(negedge clk);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    loadValid = 1'b1;
    loadRd = 5'd3;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_ready", 32'(loadReady), 32'd0);
      check("rst_we", 32'(writeEn), 32'd0);
      check("rst_addr", 32'(writeAddr), 32'd0);
      check("rst_data", writeData, 32'd0);
      check("rst_count", 32'(pendingCount), 32'd0);
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    idle_inputs();
    next_cycle();

    // ALU path, then an x0 write that must be dropped.
    aluValid = 1'b1; aluRd = 5'd5; aluResult = 32'hDEADBEEF;
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    next_cycle();
    aluRd = 5'd0; aluResult = 32'h12345678;
    next_cycle();
    aluValid = 1'b0;
    @(negedge clk);
    check("alu_x0_we", 32'(writeEn), 32'd0);
    check("alu_hold_addr", 32'(writeAddr), 32'd5);
    check("alu_hold_data", writeData, 32'hDEADBEEF);
    next_cycle();

    // Load formatting.
    do_load(5'd10, 3'b000, 2'd2, 32'hFFFFFFF1);
    do_load(5'd11, 3'b100, 2'd3, 32'h00000080);
    do_load(5'd12, 3'b001, 2'd2, 32'hFFFF80F1);
    do_load(5'd13, 3'b101, 2'd0, 32'h00007F01);
    do_load(5'd14, 3'b010, 2'd1, 32'h80F17F01);
    do_load(5'd15, 3'b011, 2'd0, 32'h80F17F01);

    // Back-pressure under continuous ALU traffic.
    for (int k = 1; k <= 5; k++) begin
      aluValid = 1'b1; aluRd = 5'd20; aluResult = 32'(k);
      loadValid = 1'b1; loadRd = 5'(k); loadData = 32'(k) * 32'h01010101;
      loadFunct3 = 3'b010; loadOffset = 2'd0;
      exp_q.push_back({5'd20, 32'(k)});
      @(negedge clk);
      if (k < 5) begin
        check("bp_ready", 32'(loadReady), 32'd1);
      end else begin
        check("bp_full_ready", 32'(loadReady), 32'd0);
        check("bp_full_count", 32'(pendingCount), 32'd4);
        check("bp_full_mask", pendingMask, 32'h0000001E);
      end
      next_cycle();
    end
    idle_inputs();
    for (int k = 1; k <= 4; k++) exp_q.push_back({5'(k), 32'(k) * 32'h01010101});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("bp_drain_we", 32'(writeEn), 32'd1);
      next_cycle();
    end
    @(negedge clk);
    check("bp_drain_count", 32'(pendingCount), 32'd0);
    next_cycle();

    // Squash: loads to x7, x9 held behind ALU traffic, then ALU x7 with a new load to x7.
    aluValid = 1'b1; aluRd = 5'd21; aluResult = 32'd1;
    loadValid = 1'b1; loadRd = 5'd7; loadData = 32'hAAAA0007;
    exp_q.push_back({5'd21, 32'd1});
    next_cycle();
    aluResult = 32'd2; loadRd = 5'd9; loadData = 32'hBBBB0009;
    exp_q.push_back({5'd21, 32'd2});
    next_cycle();
    aluRd = 5'd7; aluResult = 32'h00000077; loadRd = 5'd7; loadData = 32'hCCCC0007;
    exp_q.push_back({5'd7, 32'h00000077});
    exp_q.push_back({5'd9, 32'hBBBB0009});
    @(negedge clk);
    check("sq_mask_before", pendingMask, 32'h00000280);
    check("sq_ready", 32'(loadReady), 32'd1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("sq_mask_after", pendingMask, 32'h00000200);
    check("sq_count", 32'(pendingCount), 32'd2);
    next_cycle();
    @(negedge clk);
    check("sq_bubble_we", 32'(writeEn), 32'd0);
    check("sq_count_pop", 32'(pendingCount), 32'd1);
    next_cycle();
    @(negedge clk);
    check("sq_count_end", 32'(pendingCount), 32'd0);
    next_cycle();

    // Reset mid-stream with three live loads queued.
    for (int k = 0; k < 3; k++) begin
      aluValid = 1'b1; aluRd = 5'd22; aluResult = 32'(100 + k);
      loadValid = 1'b1; loadRd = (k == 0) ? 5'd3 : (k == 1) ? 5'd4 : 5'd6;
      loadData = 32'hDEAD0000 + 32'(k);
      exp_q.push_back({5'd22, 32'(100 + k)});
      next_cycle();
    end
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    check("mid_count_pre", 32'(pendingCount), 32'd3);
    check("mid_mask_pre", pendingMask, 32'h00000058);
    check("mid_ready_rst", 32'(loadReady), 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("mid_count", 32'(pendingCount), 32'd0);
    check("mid_mask", pendingMask, 32'd0);
    check("mid_we", 32'(writeEn), 32'd0);
    repeat (8) next_cycle();

    @(negedge clk);
    check("scoreboard_left", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
